aluv_scheduler: RTL and testbench

Sequencer and round-robin arbiter sharing one vector ALU (ALUV) between NUM_REQ requesters. Accepts one vector operation per grant over a valid/ready handshake, drives the ALU from registered operands, captures the lane-wise result and returns it to the owning requester. It sits between the vector issue ports and the single ALUV instance.

---
 rtl/aluv_pkg.sv | 21 ++
 rtl/aluv_scheduler_if.sv | 28 ++
 rtl/aluv_scheduler_rr_arbiter.sv | 32 +++
 rtl/aluv_scheduler.sv | 110 +++++++++++
 tb/tb_aluv_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aluv_pkg.sv
// Shared types and constants for the ALUV scheduler slice: opcodes, FSM states, lane vectors.
package aluv_pkg;

    localparam int ALUV_DATA_WIDTH    = 8;
    localparam int ALUV_LANES         = 8;
    localparam int ALUV_SELECTOR_SIZE = 4;

    localparam logic [3:0] ALUV_OP_ADD = 4'b0100;
    localparam logic [3:0] ALUV_OP_SUB = 4'b1101;
    localparam logic [3:0] ALUV_OP_MUL = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef logic [ALUV_LANES-1:0][ALUV_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/aluv_scheduler_if.sv
// Request/response bundle between the vector issue ports and the ALUV scheduler.
interface aluv_scheduler_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int LANES         = 8,
    parameter int SELECTOR_SIZE = 4,
    parameter int NUM_REQ       = 2
);
    logic [NUM_REQ-1:0]                              req_valid;
    logic [NUM_REQ-1:0]                              req_ready;
    logic [NUM_REQ-1:0][SELECTOR_SIZE-1:0]           req_selector;
    logic [NUM_REQ-1:0][LANES-1:0][DATA_WIDTH-1:0]   req_op1;
    logic [NUM_REQ-1:0][LANES-1:0][DATA_WIDTH-1:0]   req_op2;
    logic [NUM_REQ-1:0]                              rsp_valid;
    logic [NUM_REQ-1:0]                              rsp_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0]                rsp_data;

    // Scheduler side.
    modport slave (
        input  req_valid, req_selector, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

    // Requester side.
    modport master (
        output req_valid, req_selector, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/aluv_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request after last_grant, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/aluv_scheduler.sv
// Shares one vector ALU between NUM_REQ requesters: arbitrate, latch operands, execute, respond.
// Define ALUV_SCHED_MUL_MULTICYCLE_EN to give MUL an extra EXEC2 cycle before capture.
module aluv_scheduler
    import aluv_pkg::*;
#(
    parameter int DATA_WIDTH    = ALUV_DATA_WIDTH,
    parameter int LANES         = ALUV_LANES,
    parameter int SELECTOR_SIZE = ALUV_SELECTOR_SIZE,
    parameter int NUM_REQ       = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    aluv_scheduler_if.slave                  bus,
    output logic [SELECTOR_SIZE-1:0]         alu_selector,
    output logic [LANES-1:0][DATA_WIDTH-1:0] alu_operand1,
    output logic [LANES-1:0][DATA_WIDTH-1:0] alu_operand2,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] alu_out,
    output logic                             busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                           state_reg;
    logic [IDX_W-1:0]                 last_grant_reg;
    logic [IDX_W-1:0]                 owner_reg;
    logic [SELECTOR_SIZE-1:0]         sel_reg;
    logic [LANES-1:0][DATA_WIDTH-1:0] op1_reg;
    logic [LANES-1:0][DATA_WIDTH-1:0] op2_reg;
    logic [LANES-1:0][DATA_WIDTH-1:0] result_reg;
    logic [NUM_REQ-1:0]               rsp_valid_reg;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (bus.req_valid),
        .last_grant  (last_grant_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Ready is only offered while idle, so at most one request is taken per operation.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = (state_reg == ST_IDLE) && grant[gi];
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = result_reg;
    assign alu_selector  = sel_reg;
    assign alu_operand1  = op1_reg;
    assign alu_operand2  = op2_reg;
    assign busy          = (state_reg != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            owner_reg      <= '0;
            sel_reg        <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            result_reg     <= '0;
            rsp_valid_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        sel_reg        <= bus.req_selector[grant_idx];
                        op1_reg        <= bus.req_op1[grant_idx];
                        op2_reg        <= bus.req_op2[grant_idx];
                        owner_reg      <= grant_idx;
                        last_grant_reg <= grant_idx;
                        state_reg      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ALUV_SCHED_MUL_MULTICYCLE_EN
                    if (sel_reg == SELECTOR_SIZE'(ALUV_OP_MUL)) begin
                        state_reg <= ST_EXEC2;
                    end else begin
                        result_reg    <= alu_out;
                        rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                        state_reg     <= ST_RESP;
                    end
`else
                    result_reg    <= alu_out;
                    rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                    state_reg     <= ST_RESP;
`endif
                end
`ifdef ALUV_SCHED_MUL_MULTICYCLE_EN
                ST_EXEC2: begin
                    result_reg    <= alu_out;
                    rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                    state_reg     <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (bus.rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aluv_scheduler.sv
// Scoreboard bench for aluv_scheduler with a behavioural ALUV; honours ALUV_SCHED_MUL_MULTICYCLE_EN.
module tb_aluv_scheduler;
    import aluv_pkg::*;

    localparam int DW = 8;
    localparam int LN = 8;
    localparam int SS = 4;
    localparam int NR = 2;
`ifdef ALUV_SCHED_MUL_MULTICYCLE_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 2;
`endif

    typedef logic [LN*DW-1:0] vec_t;
    typedef struct packed {
        logic [NR-1:0] owner;
        logic [SS-1:0] sel;
        vec_t          a;
        vec_t          b;
        vec_t          data;
    } exp_t;

    localparam vec_t A0 = 64'h1020304050607080;
    localparam vec_t B0 = 64'h0101010101010101;
    localparam vec_t E0 = 64'h1121314151617181;
    localparam vec_t A1 = 64'h0001020304050607;
    localparam vec_t B1 = 64'h0101010101010101;
    localparam vec_t E1 = 64'hFF00010203040506;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [SS-1:0]        alu_selector;
    logic [LN-1:0][DW-1:0] alu_operand1;
    logic [LN-1:0][DW-1:0] alu_operand2;
    logic [LN-1:0][DW-1:0] alu_out;
    logic                 busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    aluv_scheduler_if #(.DATA_WIDTH(DW), .LANES(LN), .SELECTOR_SIZE(SS), .NUM_REQ(NR)) bus ();

    aluv_scheduler #(.DATA_WIDTH(DW), .LANES(LN), .SELECTOR_SIZE(SS), .NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_selector (alu_selector),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_out      (alu_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALUV, lane-wise with wrap-around.
    function automatic vec_t alu_ref(input logic [SS-1:0] sel, input vec_t a, input vec_t b);
        vec_t          r;
        logic [DW-1:0] x, y;
        r = '0;
        for (int l = 0; l < LN; l++) begin
            x = a[l*DW +: DW];
            y = b[l*DW +: DW];
            case (sel)
                ALUV_OP_ADD: r[l*DW +: DW] = x + y;
                ALUV_OP_SUB: r[l*DW +: DW] = x - y;
                ALUV_OP_MUL: r[l*DW +: DW] = x * y;
                default:     r[l*DW +: DW] = '0;
            endcase
        end
        return r;
    endfunction

    assign alu_out = alu_ref(alu_selector, alu_operand1, alu_operand2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_req(input int r, input logic [SS-1:0] sel, input vec_t a, input vec_t b);
        bus.req_valid[r]    = 1'b1;
        bus.req_selector[r] = sel;
        bus.req_op1[r]      = a;
        bus.req_op2[r]      = b;
    endtask

    task automatic push_exp(input logic [NR-1:0] owner, input logic [SS-1:0] sel,
                            input vec_t a, input vec_t b, input vec_t data);
        exp_t e;
        e.owner = owner;
        e.sel   = sel;
        e.a     = a;
        e.b     = b;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    task automatic wait_accept(output logic [NR-1:0] rdy);
        rdy = '0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (bus.req_ready != '0) begin
                rdy = bus.req_ready;
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Called in the accept cycle; follows the op through EXEC until rsp_valid appears.
    task automatic collect_rsp(input int exp_lat, input bit drop_valid, input bit do_ready);
        exp_t e;
        int   lat;
        bit   seen;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e    = sb_q.pop_front();
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            if (drop_valid && lat == 0) bus.req_valid = bus.req_valid & ~e.owner;
            lat++;
            #1;
            if (lat == 1) begin
                check("exec_busy", 64'(busy), 64'd1);
                check("exec_req_ready", 64'(bus.req_ready), 64'd0);
                check("exec_alu_sel", 64'(alu_selector), 64'(e.sel));
                check("exec_alu_op1", 64'(alu_operand1), e.a);
                check("exec_alu_op2", 64'(alu_operand2), e.b);
            end
            if (bus.rsp_valid != '0) seen = 1'b1;
        end
        if (!seen) begin
            check("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        check("rsp_latency", 64'(lat), 64'(exp_lat));
        check("rsp_valid_owner", 64'(bus.rsp_valid), 64'(e.owner));
        check("rsp_data", 64'(bus.rsp_data), e.data);
        $display("txn owner=%b sel=%h op1=%h op2=%h data=%h lat=%0d",
                 e.owner, e.sel, e.a, e.b, bus.rsp_data, lat);
        if (do_ready) begin
            bus.rsp_ready = e.owner;
            @(negedge clk);
            bus.rsp_ready = '0;
            #1;
            check("post_hs_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("post_hs_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic run_op(input int r, input logic [SS-1:0] sel, input vec_t a, input vec_t b,
                          input vec_t exp_data, input int exp_lat);
        logic [NR-1:0] rdy;
        logic [NR-1:0] oh;
        oh = NR'(1) << r;
        @(negedge clk);
        drive_req(r, sel, a, b);
        wait_accept(rdy);
        check("grant", 64'(rdy), 64'(oh));
        push_exp(oh, sel, a, b, exp_data);
        collect_rsp(exp_lat, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] rdy;
        logic [NR-1:0] exp_oh;
        vec_t          ra, rb;
        logic [SS-1:0] rsel;
        int            rr;

        bus.req_valid    = '0;
        bus.req_selector = '0;
        bus.req_op1      = '0;
        bus.req_op2      = '0;
        bus.rsp_ready    = '0;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_alu_sel", 64'(alu_selector), 64'd0);
        check("rst_alu_op1", 64'(alu_operand1), 64'd0);
        check("rst_alu_op2", 64'(alu_operand2), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed ops from the plan
        run_op(0, ALUV_OP_ADD, 64'h01040205FF050005, 64'h010504060F080802, 64'h0209060B0E0D0807, 2);
        run_op(1, ALUV_OP_SUB, 64'h0404040404040404, 64'h0606060606060606, 64'hFEFEFEFEFEFEFEFE, 2);
        run_op(0, ALUV_OP_MUL, 64'h0E0E0E0E0E0E0E0E, 64'h0202020202020202, 64'h1C1C1C1C1C1C1C1C, MUL_LAT);

        // Both requesters valid continuously: grants must alternate starting at req0
        reset_dut();
        @(negedge clk);
        drive_req(0, ALUV_OP_ADD, A0, B0);
        drive_req(1, ALUV_OP_SUB, A1, B1);
        for (int k = 0; k < 4; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_accept(rdy);
            check("alt_grant", 64'(rdy), 64'(exp_oh));
            if (k % 2 == 0) push_exp(exp_oh, ALUV_OP_ADD, A0, B0, E0);
            else            push_exp(exp_oh, ALUV_OP_SUB, A1, B1, E1);
            collect_rsp(2, 1'b0, 1'b1);
            if (k == 3) bus.req_valid = '0;
        end

        // Backpressure on req0 with req1 pending
        reset_dut();
        @(negedge clk);
        drive_req(0, ALUV_OP_ADD, A0, B0);
        drive_req(1, ALUV_OP_SUB, A1, B1);
        wait_accept(rdy);
        check("bp_grant0", 64'(rdy), 64'd1);
        push_exp(2'b01, ALUV_OP_ADD, A0, B0, E0);
        collect_rsp(2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_rsp_data", 64'(bus.rsp_data), E0);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        #1;
        check("bp_nonowner_ready", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = '0;
        #1;
        check("bp_rsp_released", 64'(bus.rsp_valid), 64'd0);
        wait_accept(rdy);
        check("bp_grant1", 64'(rdy), 64'd2);
        push_exp(2'b10, ALUV_OP_SUB, A1, B1, E1);
        collect_rsp(2, 1'b1, 1'b1);

        // Random single-requester ops
        for (int n = 0; n < 6; n++) begin
            rr   = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       rsel = ALUV_OP_ADD;
                1:       rsel = ALUV_OP_SUB;
                default: rsel = ALUV_OP_MUL;
            endcase
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(rr, rsel, ra, rb, alu_ref(rsel, ra, rb), (rsel == ALUV_OP_MUL) ? MUL_LAT : 2);
        end

        // Reset during EXEC discards the operation
        @(negedge clk);
        drive_req(0, ALUV_OP_MUL, 64'h0E0E0E0E0E0E0E0E, 64'h0202020202020202);
        wait_accept(rdy);
        check("abort_grant", 64'(rdy), 64'd1);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("abort_in_exec", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_req_ready", 64'(bus.req_ready), 64'd0);
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("abort_alu_sel", 64'(alu_selector), 64'd0);
        check("abort_alu_op1", 64'(alu_operand1), 64'd0);
        check("abort_alu_op2", 64'(alu_operand2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
            check("abort_idle", 64'(busy), 64'd0);
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
